// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS multi-cycle control sequencer.
package mips_cpu_pkg;

  // Sequencer states; encodings are visible on the state debug output.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } seq_state_t;

  // Bus address source select.
  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;

endpackage

// File: rtl/mips_seq_wait_timer.sv
// Counts consecutive stalled cycles of one bus cycle and flags a timeout.
// LIMIT = 0 disables the timeout entirely.
module mips_seq_wait_timer #(
  parameter logic [15:0] LIMIT = 16'd0
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic clear,
  output logic expired
);

  localparam logic [15:0] LAST = LIMIT - 16'd1;

  logic [15:0] count;

  // Consecutive-stall counter; cleared whenever the bus cycle completes.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 16'd0;
    end else if (stall) begin
      count <= count + 16'd1;
    end
  end

  // Fires during the Nth stalled cycle so the sequencer halts on that edge.
  assign expired = (LIMIT != 16'd0) && stall && (count == LAST);

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALTED.
// Optional macro MIPS_SEQ_PERF_EN adds the instr_retired and stall_cycles
// performance counters; without it both outputs are tied to zero.
//
// Bus handshake: the sequencer presents mem_read/mem_write (Moore, from the
// state) and holds them; the memory holds waitrequest high while busy. A bus
// cycle completes on the rising edge where clk_enable=1 and waitrequest=0.
// Stalled cycles are those with clk_enable=1 and waitrequest=1.
module mips_cpu_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [15:0] WAIT_TIMEOUT = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        waitrequest,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        reg_write_req,
  input  logic        pc_next_zero,
  output logic        active,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        regfile_write,
  output logic        bus_error,
  output logic [2:0]  state,
  output logic [31:0] instr_retired,
  output logic [31:0] stall_cycles
);

  seq_state_t cur_state;
  seq_state_t next_state;
  logic       stall;
  logic       bus_done;
  logic       timer_expired;

  // State register; reset wins over clk_enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next state, Moore bus strobes and clk_enable-gated datapath pulses.
  always_comb begin
    next_state    = cur_state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    addr_sel      = ADDR_SEL_PC;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    regfile_write = 1'b0;
    bus_done      = 1'b0;
    stall         = 1'b0;
    case (cur_state)
      FETCH: begin
        mem_read = 1'b1;
        if (clk_enable) begin
          if (!waitrequest) begin
            ir_write   = 1'b1;
            bus_done   = 1'b1;
            next_state = DECODE;
          end else begin
            stall = 1'b1;
          end
        end
      end
      DECODE: begin
        if (clk_enable) next_state = EXEC;
      end
      EXEC: begin
        if (clk_enable) next_state = (is_load || is_store) ? MEM : WB;
      end
      MEM: begin
        addr_sel  = ADDR_SEL_ALU;
        mem_read  = is_load;
        // Load takes priority so the two strobes are mutually exclusive.
        mem_write = is_store && !is_load;
        if (clk_enable) begin
          if (!waitrequest) begin
            bus_done = 1'b1;
            if (is_load) begin
              next_state = WB;
            end else begin
              pc_write   = 1'b1;
              next_state = pc_next_zero ? HALTED : FETCH;
            end
          end else begin
            stall = 1'b1;
          end
        end
      end
      WB: begin
        if (clk_enable) begin
          regfile_write = reg_write_req;
          pc_write      = 1'b1;
          next_state    = pc_next_zero ? HALTED : FETCH;
        end
      end
      HALTED: begin
        next_state = HALTED;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
    if (timer_expired) next_state = HALTED;
    // An instruction aborted by reset must not write anything.
    if (reset) begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      regfile_write = 1'b0;
    end
  end

  mips_seq_wait_timer #(
    .LIMIT (WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .clear   (bus_done),
    .expired (timer_expired)
  );

  // Sticky bus error, set when a bus cycle times out.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_error <= 1'b0;
    end else if (timer_expired) begin
      bus_error <= 1'b1;
    end
  end

`ifdef MIPS_SEQ_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  // Performance counters: retirements on pc_write, stalls on bus wait cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      if (pc_write) retired_q <= retired_q + 32'd1;
      if (stall)    stall_q   <= stall_q + 32'd1;
    end
  end

  assign instr_retired = retired_q;
  assign stall_cycles  = stall_q;
`else
  assign instr_retired = 32'd0;
  assign stall_cycles  = 32'd0;
`endif

  assign active = (cur_state != HALTED);
  assign state  = cur_state;

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Self-checking bench for mips_cpu_sequencer: a default instance for the
// instruction flows and a WAIT_TIMEOUT=8 instance for the bus timeout.
module tb_mips_cpu_sequencer;
  import mips_cpu_pkg::*;

`ifdef MIPS_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic reset2 = 1'b1;
  logic clk_enable = 1'b0;
  logic waitrequest = 1'b0;
  logic waitrequest2 = 1'b0;
  logic is_load = 1'b0;
  logic is_store = 1'b0;
  logic reg_write_req = 1'b0;
  logic pc_next_zero = 1'b0;

  logic        active, mem_read, mem_write, addr_sel;
  logic        ir_write, pc_write, regfile_write, bus_error;
  logic [2:0]  state;
  logic [31:0] instr_retired, stall_cycles;

  logic        t_active, t_mem_read, t_mem_write, t_addr_sel;
  logic        t_ir_write, t_pc_write, t_regfile_write, t_bus_error;
  logic [2:0]  t_state;
  logic [31:0] t_instr_retired, t_stall_cycles;

  mips_cpu_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .waitrequest   (waitrequest),
    .is_load       (is_load),
    .is_store      (is_store),
    .reg_write_req (reg_write_req),
    .pc_next_zero  (pc_next_zero),
    .active        (active),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .addr_sel      (addr_sel),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .regfile_write (regfile_write),
    .bus_error     (bus_error),
    .state         (state),
    .instr_retired (instr_retired),
    .stall_cycles  (stall_cycles)
  );

  mips_cpu_sequencer #(.WAIT_TIMEOUT(16'd8)) dut_to (
    .clk           (clk),
    .reset         (reset2),
    .clk_enable    (clk_enable),
    .waitrequest   (waitrequest2),
    .is_load       (is_load),
    .is_store      (is_store),
    .reg_write_req (reg_write_req),
    .pc_next_zero  (pc_next_zero),
    .active        (t_active),
    .mem_read      (t_mem_read),
    .mem_write     (t_mem_write),
    .addr_sel      (t_addr_sel),
    .ir_write      (t_ir_write),
    .pc_write      (t_pc_write),
    .regfile_write (t_regfile_write),
    .bus_error     (t_bus_error),
    .state         (t_state),
    .instr_retired (t_instr_retired),
    .stall_cycles  (t_stall_cycles)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  int exp_retired = 0;
  int exp_stall   = 0;

  // ---------------- scoreboard ----------------
  // Entry: {regfile_write expected at retirement, cycles from ir_write to pc_write}.
  logic [7:0] exp_q[$];
  logic [7:0] sb_e;
  int         sb_lat = 0;
  bit         sb_running = 1'b0;

  // Retirement monitor: pops one expectation per pc_write pulse.
  always @(negedge clk) begin
    if (reset) begin
      sb_running = 1'b0;
    end else begin
      if (ir_write) begin
        sb_running = 1'b1;
        sb_lat = 1;
      end else if (sb_running) begin
        sb_lat++;
      end
      if (pc_write) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_retire", 32'd1, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_regfile_write", 32'(regfile_write), 32'(sb_e[7]));
          check("sb_latency", 32'(sb_lat), 32'(sb_e[6:0]));
        end
        sb_running = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_enable = 1'b0;
    waitrequest = 1'b0;
    is_load = 1'b0;
    is_store = 1'b0;
    reg_write_req = 1'b0;
    pc_next_zero = 1'b0;
    tick();
    // clk_enable high with an idle bus would pulse ir_write if reset did not win.
    clk_enable = 1'b1;
    @(negedge clk);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_state", 32'(state), 32'(FETCH));
    check("rst_active", 32'(active), 32'd1);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_retired", instr_retired, 32'd0);
    check("rst_stall", stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_retired = 0;
    exp_stall = 0;
    exp_q.delete();
  endtask

  // Runs one instruction on a pre-computed cycle timeline. In MEM the bus is
  // frozen for freeze_n cycles (clk_enable low, waitrequest high, which must
  // not count) then stalled for wait_n cycles.
  task automatic run_instr(input bit ld, input bit st, input bit rw, input bit pz,
                           input int wait_n, input int freeze_n);
    int  total;
    bit  rf_exp;
    bit  in_mem;
    bit  frz;
    bit  wt;
    total = (ld ? 5 : 4) + wait_n + freeze_n;
    rf_exp = rw && !st;
    is_load = ld;
    is_store = st;
    reg_write_req = rw;
    pc_next_zero = pz;
    exp_q.push_back({rf_exp, 7'(total)});
    for (int c = 1; c <= total; c++) begin
      frz = (c >= 4) && (c < 4 + freeze_n);
      wt  = (c >= 4 + freeze_n) && (c < 4 + freeze_n + wait_n);
      clk_enable = !frz;
      waitrequest = frz || wt;
      in_mem = (ld || st) && (c >= 4) && (c <= 4 + freeze_n + wait_n);
      @(negedge clk);
      if (c == 1) begin
        check("fetch_mem_read", 32'(mem_read), 32'd1);
        check("fetch_addr_sel", 32'(addr_sel), 32'(ADDR_SEL_PC));
      end
      if (in_mem) begin
        check("mem_state", 32'(state), 32'(MEM));
        check("mem_read", 32'(mem_read), 32'(ld));
        check("mem_write", 32'(mem_write), 32'(st));
        check("mem_addr_sel", 32'(addr_sel), 32'(ADDR_SEL_ALU));
      end
      if (frz) check("freeze_stall", stall_cycles, perf_exp(exp_stall));
      check("ir_write", 32'(ir_write), 32'(c == 1));
      check("rf_write", 32'(regfile_write), 32'((c == total) && rf_exp));
      @(posedge clk);
      #1;
    end
    clk_enable = 1'b1;
    waitrequest = 1'b0;
    exp_retired++;
    exp_stall += wait_n;
    check("end_state", 32'(state), pz ? 32'(HALTED) : 32'(FETCH));
    check("end_active", 32'(active), 32'(!pz));
    check("instr_retired", instr_retired, perf_exp(exp_retired));
    check("stall_cycles", stall_cycles, perf_exp(exp_stall));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int w;
    do_reset();

    // ALU ops, loads with stalls, stores, frozen store
    run_instr(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 3, 0);
    run_instr(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 0, 5);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    // Random instruction mix
    for (int i = 0; i < 8; i++) begin
      kind = $urandom_range(0, 2);
      w = (kind == 0) ? 0 : $urandom_range(0, 3);
      run_instr(kind == 1, kind == 2, 1'($urandom_range(0, 1)), 1'b0, w, 0);
    end

    // Halt via next PC of zero; further instructions are ignored
    run_instr(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    is_load = 1'b0;
    is_store = 1'b0;
    pc_next_zero = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("halt_state", 32'(state), 32'(HALTED));
      check("halt_ir_write", 32'(ir_write), 32'd0);
      check("halt_mem_read", 32'(mem_read), 32'd0);
      check("halt_pc_write", 32'(pc_write), 32'd0);
      tick();
    end
    check("halt_retired", instr_retired, perf_exp(exp_retired));

    // Reset aborts a store stalled in MEM
    do_reset();
    is_store = 1'b1;
    reg_write_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      waitrequest = (c >= 4);
      tick();
    end
    reset = 1'b1;
    waitrequest = 1'b0;
    @(negedge clk);
    check("abort_mem_write_held", 32'(mem_write), 32'd1);
    check("abort_pc_write", 32'(pc_write), 32'd0);
    check("abort_rf_write", 32'(regfile_write), 32'd0);
    tick();
    reset = 1'b0;
    is_store = 1'b0;
    reg_write_req = 1'b0;
    waitrequest = 1'b1;
    @(negedge clk);
    check("abort_mem_write_drop", 32'(mem_write), 32'd0);
    check("abort_state", 32'(state), 32'(FETCH));
    check("abort_retired", instr_retired, 32'd0);
    check("abort_stall", stall_cycles, 32'd0);

    // Bus timeout on the WAIT_TIMEOUT=8 instance, main instance held in reset
    reset = 1'b1;
    waitrequest = 1'b0;
    clk_enable = 1'b1;
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    waitrequest2 = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    check("to_7_state", 32'(t_state), 32'(FETCH));
    check("to_7_err", 32'(t_bus_error), 32'd0);
    waitrequest2 = 1'b0;
    tick();
    check("to_done_state", 32'(t_state), 32'(DECODE));
    for (int c = 0; c < 3; c++) tick();
    check("to_back_fetch", 32'(t_state), 32'(FETCH));
    waitrequest2 = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    check("to_clear_state", 32'(t_state), 32'(FETCH));
    check("to_clear_err", 32'(t_bus_error), 32'd0);
    tick();
    check("to_8_state", 32'(t_state), 32'(HALTED));
    check("to_8_err", 32'(t_bus_error), 32'd1);
    check("to_8_active", 32'(t_active), 32'd0);
    check("to_8_stall", t_stall_cycles, perf_exp(15));
    reset2 = 1'b1;
    tick();
    check("to_rst_err", 32'(t_bus_error), 32'd0);
    check("to_rst_state", 32'(t_state), 32'(FETCH));
    waitrequest2 = 1'b0;

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
